fetch_decode_buffer: RTL and testbench

Two-entry instruction buffer between the fetch stage and the decode stage. It captures {instruction, PC, PC+2} from fetch under a valid/ready handshake and presents them in order to decode. It absorbs one cycle of decode stall without losing a fetched instruction, and it kills wrong-path instructions on a redirect flush. It also detects HALT and stops further fetch acceptance until a flush or reset.

---
 rtl/fetch_decode_buffer_pkg.sv | 23 ++
 rtl/fetch_decode_buffer_fbuf_slot.sv | 30 +++
 rtl/fetch_decode_buffer.sv | 104 ++++++++++
 tb/tb_fetch_decode_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared constants and helpers for the fetch/decode instruction buffer.
// Opcode fields assume a 16-bit instruction encoding in the low bits of each word.
package fetch_decode_buffer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [4:0]  OP_HALT    = 5'b00000;
    localparam int          OPCODE_MSB = 15;
    localparam int          OPCODE_LSB = 11;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] next_pc;
    } fetch_word_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_fbuf_slot.sv
// One buffer entry holding {instruction, PC, PC+2}; resets to a NOP at PC 0.
module fbuf_slot
    import fetch_decode_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] q_instr,
    output logic [WIDTH-1:0] q_pc,
    output logic [WIDTH-1:0] q_next_pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_instr   <= WIDTH'(NOP_INSTR);
            q_pc      <= '0;
            q_next_pc <= '0;
        end else if (we) begin
            q_instr   <= instr;
            q_pc      <= pc;
            q_next_pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Two-entry FIFO between fetch and decode with redirect flush and HALT freeze.
// f_ready is computed from registered state and flush only, so no path from d_ready.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [WIDTH-1:0] f_instr,
    input  logic [WIDTH-1:0] f_pc,
    input  logic [WIDTH-1:0] f_next_pc,
    output logic             f_ready,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_instr,
    output logic [WIDTH-1:0] d_pc,
    output logic [WIDTH-1:0] d_next_pc,
    input  logic             d_ready,
    input  logic             flush,
    output logic             halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] slot_instr   [DEPTH];
    logic [WIDTH-1:0] slot_pc      [DEPTH];
    logic [WIDTH-1:0] slot_next_pc [DEPTH];
    logic [WIDTH-1:0] hold_pc;
    logic [WIDTH-1:0] hold_next_pc;

    assign d_valid = (count != '0);
    assign f_ready = (count < CNT_W'(DEPTH)) & ~halted & ~flush;
    assign push    = f_valid & f_ready;
    assign pop     = d_valid & d_ready & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        fbuf_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .we        (push && (wr_ptr == PTR_W'(i))),
            .instr     (f_instr),
            .pc        (f_pc),
            .next_pc   (f_next_pc),
            .q_instr   (slot_instr[i]),
            .q_pc      (slot_pc[i]),
            .q_next_pc (slot_next_pc[i])
        );
    end

    // PC fields keep showing the last head seen once the buffer runs dry.
    assign d_instr   = d_valid ? slot_instr[rd_ptr]   : WIDTH'(NOP_INSTR);
    assign d_pc      = d_valid ? slot_pc[rd_ptr]      : hold_pc;
    assign d_next_pc = d_valid ? slot_next_pc[rd_ptr] : hold_next_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (flush) begin
            halted <= 1'b0;
        end else if (push && is_halt(f_instr[15:0])) begin
            halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pc      <= '0;
            hold_next_pc <= '0;
        end else if (d_valid) begin
            hold_pc      <= slot_pc[rd_ptr];
            hold_next_pc <= slot_next_pc[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench: directed vector table, mid-stream reset, and random traffic
// compared against a queue-based reference model of the buffer.
module tb_fetch_decode_buffer;
    import fetch_decode_buffer_pkg::*;

    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         f_valid = 1'b0;
    logic [W-1:0] f_instr = '0;
    logic [W-1:0] f_pc = '0;
    logic [W-1:0] f_next_pc = '0;
    logic         f_ready;
    logic         d_valid;
    logic [W-1:0] d_instr;
    logic [W-1:0] d_pc;
    logic [W-1:0] d_next_pc;
    logic         d_ready = 1'b0;
    logic         flush = 1'b0;
    logic         halted;

    int checks = 0;
    int errors = 0;

    fetch_decode_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .f_next_pc (f_next_pc),
        .f_ready   (f_ready),
        .d_valid   (d_valid),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_next_pc (d_next_pc),
        .d_ready   (d_ready),
        .flush     (flush),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        dr;
        logic        fl;
        logic        exp_dv;
        logic [15:0] exp_di;
        logic [15:0] exp_pc;
        logic        exp_fr;
        logic        exp_h;
    } vec_t;

    vec_t vecs[$];

    fetch_word_t model_q[$];
    logic        model_halted;
    logic [15:0] model_last_pc;
    logic [15:0] model_last_npc;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fv, input logic [15:0] instr, input logic [15:0] pc,
                                input logic dr, input logic fl, input logic dv,
                                input logic [15:0] di, input logic [15:0] dpc,
                                input logic fr, input logic h);
        vec_t v;
        v.fv = fv; v.instr = instr; v.pc = pc; v.dr = dr; v.fl = fl;
        v.exp_dv = dv; v.exp_di = di; v.exp_pc = dpc; v.exp_fr = fr; v.exp_h = h;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge; outputs settle before the rising edge.
    task automatic apply_stimulus(input logic fv, input logic [15:0] instr, input logic [15:0] pc,
                                  input logic dr, input logic fl);
        @(negedge clk);
        f_valid   = fv;
        f_instr   = instr;
        f_pc      = pc;
        f_next_pc = pc + 16'd2;
        d_ready   = dr;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        model_halted   = 1'b0;
        model_last_pc  = '0;
        model_last_npc = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_d_valid"},   {15'd0, d_valid}, 16'd0);
        check_output({tag, "_d_instr"},   d_instr, 16'h0800);
        check_output({tag, "_d_pc"},      d_pc, 16'h0000);
        check_output({tag, "_d_next_pc"}, d_next_pc, 16'h0000);
        check_output({tag, "_f_ready"},   {15'd0, f_ready}, 16'd1);
        check_output({tag, "_halted"},    {15'd0, halted}, 16'd0);
    endtask

    // Reference model: outputs from the queue contents, then advance one clock.
    task automatic model_cycle(input logic fv, input logic [15:0] instr, input logic [15:0] pc,
                               input logic dr, input logic fl);
        logic        dv;
        logic        fr;
        fetch_word_t w;
        dv = (model_q.size() != 0);
        fr = (model_q.size() < D) && !model_halted && !fl;
        check_output("rand_d_valid", {15'd0, d_valid}, {15'd0, dv});
        check_output("rand_d_instr", d_instr, dv ? model_q[0].instr : NOP_INSTR);
        check_output("rand_d_pc", d_pc, dv ? model_q[0].pc : model_last_pc);
        check_output("rand_d_next_pc", d_next_pc, dv ? model_q[0].next_pc : model_last_npc);
        check_output("rand_f_ready", {15'd0, f_ready}, {15'd0, fr});
        check_output("rand_halted", {15'd0, halted}, {15'd0, model_halted});
        if (dv) begin
            model_last_pc  = model_q[0].pc;
            model_last_npc = model_q[0].next_pc;
        end
        if (fl) begin
            model_q.delete();
            model_halted = 1'b0;
        end else begin
            if (dv && dr) void'(model_q.pop_front());
            if (fv && fr) begin
                w.instr = instr; w.pc = pc; w.next_pc = pc + 16'd2;
                model_q.push_back(w);
                if (instr[15:11] == 5'b00000) model_halted = 1'b1;
            end
        end
    endtask

    initial begin
        // fv instr  pc     dr fl | dv di      d_pc    fr h
        vecs.push_back(mk(1, 16'h1234, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 16'h5678, 16'h0002, 1, 0, 1, 16'h1234, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h5678, 16'h0002, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0002, 1, 0));
        vecs.push_back(mk(1, 16'h1111, 16'h0010, 0, 0, 0, 16'h0800, 16'h0002, 1, 0));
        vecs.push_back(mk(1, 16'h2222, 16'h0012, 0, 0, 1, 16'h1111, 16'h0010, 1, 0));
        vecs.push_back(mk(1, 16'h3333, 16'h0014, 0, 0, 1, 16'h1111, 16'h0010, 0, 0));
        vecs.push_back(mk(1, 16'h3333, 16'h0014, 1, 0, 1, 16'h1111, 16'h0010, 0, 0));
        vecs.push_back(mk(1, 16'h3333, 16'h0014, 1, 0, 1, 16'h2222, 16'h0012, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h3333, 16'h0014, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0014, 1, 0));
        vecs.push_back(mk(1, 16'hAAAA, 16'h0020, 0, 0, 0, 16'h0800, 16'h0014, 1, 0));
        vecs.push_back(mk(1, 16'hBBBB, 16'h0022, 0, 0, 1, 16'hAAAA, 16'h0020, 1, 0));
        vecs.push_back(mk(1, 16'hCCCC, 16'h0024, 1, 1, 1, 16'hAAAA, 16'h0020, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0020, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0020, 1, 0));
        vecs.push_back(mk(1, 16'h4000, 16'h0030, 0, 0, 0, 16'h0800, 16'h0020, 1, 0));
        vecs.push_back(mk(1, 16'h0000, 16'h0032, 0, 0, 1, 16'h4000, 16'h0030, 1, 0));
        vecs.push_back(mk(1, 16'h5555, 16'h0034, 1, 0, 1, 16'h4000, 16'h0030, 0, 1));
        vecs.push_back(mk(1, 16'h5555, 16'h0034, 1, 0, 1, 16'h0000, 16'h0032, 0, 1));
        vecs.push_back(mk(1, 16'h5555, 16'h0034, 1, 0, 0, 16'h0800, 16'h0032, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0800, 16'h0032, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0032, 1, 0));
        vecs.push_back(mk(1, 16'h6666, 16'h0040, 0, 0, 0, 16'h0800, 16'h0032, 1, 0));
        vecs.push_back(mk(1, 16'h7777, 16'h0042, 1, 0, 1, 16'h6666, 16'h0040, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h7777, 16'h0042, 1, 0));
        vecs.push_back(mk(1, 16'h8888, 16'h0044, 0, 0, 1, 16'h7777, 16'h0042, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h7777, 16'h0042, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h7777, 16'h0042, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h8888, 16'h0044, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0044, 1, 0));

        #1;
        check_reset_values("reset");
        do_reset();

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].fv, vecs[i].instr, vecs[i].pc, vecs[i].dr, vecs[i].fl);
            check_output($sformatf("vec%0d_d_valid", i), {15'd0, d_valid}, {15'd0, vecs[i].exp_dv});
            check_output($sformatf("vec%0d_d_instr", i), d_instr, vecs[i].exp_di);
            check_output($sformatf("vec%0d_d_pc", i), d_pc, vecs[i].exp_pc);
            check_output($sformatf("vec%0d_f_ready", i), {15'd0, f_ready}, {15'd0, vecs[i].exp_fr});
            check_output($sformatf("vec%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_h});
        end

        // Fill the buffer, then pull reset low between clock edges.
        apply_stimulus(1, 16'h9001, 16'h0100, 0, 0);
        apply_stimulus(1, 16'h0000, 16'h0102, 0, 0);
        apply_stimulus(0, 16'h0000, 16'h0000, 0, 0);
        check_output("pre_reset_d_valid", {15'd0, d_valid}, 16'd1);
        check_output("pre_reset_halted", {15'd0, halted}, 16'd1);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        model_halted   = 1'b0;
        model_last_pc  = '0;
        model_last_npc = '0;

        for (int c = 0; c < 600; c++) begin
            logic        fv;
            logic        dr;
            logic        fl;
            logic [15:0] instr;
            logic [15:0] pc;
            fv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            instr = 16'($urandom);
            if (instr[15:11] == 5'b00000 || $urandom_range(0, 11) == 0)
                instr[15:11] = ($urandom_range(0, 11) == 0) ? 5'b00000 : 5'b00001;
            pc = 16'($urandom) & 16'hFFFE;
            apply_stimulus(fv, instr, pc, dr, fl);
            model_cycle(fv, instr, pc, dr, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
